// File: rtl/instruction_sequencer.sv
// Byte-stream program loader and one-word-per-clock instruction issuer for the cpu block.
// Stored words are replayed on start, with NOP padding after tensor-core operates and READ results captured.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | output NOP, waiting for a first program byte or a start request
// LOAD  | packing bytes little-endian into words and committing to memory
// RUN   | issuing stored words, inserting NOP stall cycles after 8'h05
module instruction_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TC_STALL = 4
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic [7:0]                 load_byte_in,
    input  logic                       load_valid_in,
    input  logic                       load_last_in,
    output logic                       load_ready_out,
    input  logic                       start_in,
    output logic [31:0]                current_instruction_out,
    input  logic signed [3:0]          cpu_output_in,
    output logic signed [3:0]          result_data_out,
    output logic                       result_valid_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [$clog2(DEPTH):0]     program_length_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = (TC_STALL > 0) ? $clog2(TC_STALL + 1) : 1;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0008;
    localparam logic [7:0]  OP_TC     = 8'h05;
    localparam logic [7:0]  OP_READ_A = 8'h0F;
    localparam logic [7:0]  OP_READ_B = 8'h10;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t         state_q;
    logic [31:0]    mem [DEPTH];
    logic [23:0]    asm_q;
    logic [1:0]     byte_idx_q;
    logic [LW-1:0]  length_q;
    logic [LW-1:0]  pc_q;
    logic [SW-1:0]  stall_q;
    logic           locked_q;

    logic           accept;
    logic           commit;
    logic           fills_mem;
    logic [1:0]     eff_idx;
    logic [LW-1:0]  eff_len;
    logic [LW-1:0]  next_len;
    logic [31:0]    commit_word;
    logic [31:0]    fetch_word;

    function automatic logic [SW-1:0] stall_for(input logic [7:0] opcode);
        return (opcode == OP_TC) ? SW'(TC_STALL) : '0;
    endfunction

    // A byte accepted in IDLE always begins a fresh program at word 0, byte 0.
    always_comb begin
        eff_idx  = (state_q == LOAD) ? byte_idx_q : 2'd0;
        eff_len  = (state_q == LOAD) ? length_q : '0;
        next_len = eff_len + 1'b1;
        case (eff_idx)
            2'd0:    commit_word = {24'h0, load_byte_in};
            2'd1:    commit_word = {16'h0, load_byte_in, asm_q[7:0]};
            2'd2:    commit_word = {8'h0, load_byte_in, asm_q[15:0]};
            default: commit_word = {load_byte_in, asm_q[23:0]};
        endcase
    end

    // A full memory stays locked against new bytes until the program is run or reset.
    assign load_ready_out     = (state_q != RUN) && !locked_q;
    assign accept             = load_valid_in && load_ready_out;
    assign commit             = accept && (load_last_in || (eff_idx == 2'd3));
    assign fills_mem          = (next_len == LW'(DEPTH));
    assign fetch_word         = mem[pc_q[AW-1:0]];
    assign busy_out           = (state_q != IDLE);
    assign program_length_out = length_q;

    always_ff @(posedge clock_in) begin
        if (commit && !reset_in)
            mem[eff_len[AW-1:0]] <= commit_word;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q                 <= IDLE;
            current_instruction_out <= NOP_WORD;
            asm_q                   <= '0;
            byte_idx_q              <= '0;
            length_q                <= '0;
            pc_q                    <= '0;
            stall_q                 <= '0;
            locked_q                <= 1'b0;
            result_data_out         <= '0;
            result_valid_out        <= 1'b0;
            done_out                <= 1'b0;
        end else begin
            done_out         <= 1'b0;
            result_valid_out <= 1'b0;
            if ((current_instruction_out[7:0] == OP_READ_A) ||
                (current_instruction_out[7:0] == OP_READ_B)) begin
                result_data_out  <= cpu_output_in;
                result_valid_out <= 1'b1;
            end

            case (state_q)
                IDLE, LOAD: begin
                    current_instruction_out <= NOP_WORD;
                    if (accept) begin
                        case (eff_idx)
                            2'd0:    asm_q[7:0]   <= load_byte_in;
                            2'd1:    asm_q[15:8]  <= load_byte_in;
                            2'd2:    asm_q[23:16] <= load_byte_in;
                            default: ;
                        endcase
                        if (commit) begin
                            length_q   <= next_len;
                            byte_idx_q <= '0;
                            if (load_last_in || fills_mem)
                                state_q <= IDLE;
                            else
                                state_q <= LOAD;
                            if (fills_mem)
                                locked_q <= 1'b1;
                        end else begin
                            length_q   <= eff_len;
                            byte_idx_q <= eff_idx + 2'd1;
                            state_q    <= LOAD;
                        end
                    end else if ((state_q == IDLE) && start_in && (length_q != '0)) begin
                        // Word 0 goes out on the start edge so a 1-word run occupies RUN for one cycle.
                        current_instruction_out <= mem[0];
                        pc_q                    <= LW'(1);
                        stall_q                 <= stall_for(mem[0][7:0]);
                        locked_q                <= 1'b0;
                        state_q                 <= RUN;
                    end
                end
                RUN: begin
                    if (stall_q != '0) begin
                        current_instruction_out <= NOP_WORD;
                        stall_q                 <= stall_q - 1'b1;
                    end else if (pc_q == length_q) begin
                        current_instruction_out <= NOP_WORD;
                        done_out                <= 1'b1;
                        state_q                 <= IDLE;
                    end else begin
                        current_instruction_out <= fetch_word;
                        pc_q                    <= pc_q + 1'b1;
                        stall_q                 <= stall_for(fetch_word[7:0]);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a per-cycle vector table for load/run/capture,
// then hand-written sequences for partial words, TC stall, full memory and reset mid-run.
module tb_instruction_sequencer;
    localparam logic [31:0] NOP = 32'h0000_0008;

    logic              clock_in;
    logic              reset_in;
    logic [7:0]        load_byte_in;
    logic              load_valid_in;
    logic              load_last_in;
    logic              load_ready_out;
    logic              start_in;
    logic [31:0]       current_instruction_out;
    logic signed [3:0] cpu_output_in;
    logic signed [3:0] result_data_out;
    logic              result_valid_out;
    logic              busy_out;
    logic              done_out;
    logic [4:0]        program_length_out;

    int n_checks = 0;
    int n_errors = 0;

    instruction_sequencer #(.DEPTH(16), .TC_STALL(4)) dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .load_byte_in            (load_byte_in),
        .load_valid_in           (load_valid_in),
        .load_last_in            (load_last_in),
        .load_ready_out          (load_ready_out),
        .start_in                (start_in),
        .current_instruction_out (current_instruction_out),
        .cpu_output_in           (cpu_output_in),
        .result_data_out         (result_data_out),
        .result_valid_out        (result_valid_out),
        .busy_out                (busy_out),
        .done_out                (done_out),
        .program_length_out      (program_length_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [7:0]        b;
        logic              v;
        logic              l;
        logic              s;
        logic signed [3:0] cpu;
        logic [31:0]       e_instr;
        logic              e_ready;
        logic [4:0]        e_len;
        logic              e_busy;
        logic              e_done;
        logic              e_valid;
        logic signed [3:0] e_res;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [7:0] b, input logic v, input logic l, input logic s,
                                input logic signed [3:0] cpu, input logic [31:0] ei, input logic er,
                                input logic [4:0] el, input logic eb, input logic ed, input logic ev,
                                input logic signed [3:0] eres);
        vec_t t;
        t.b = b; t.v = v; t.l = l; t.s = s; t.cpu = cpu;
        t.e_instr = ei; t.e_ready = er; t.e_len = el; t.e_busy = eb;
        t.e_done = ed; t.e_valid = ev; t.e_res = eres;
        return t;
    endfunction

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] ei, input logic er,
                               input logic [4:0] el, input logic eb, input logic ed);
        check({tag, " instr"}, current_instruction_out, ei);
        check({tag, " ready"}, {31'h0, load_ready_out}, {31'h0, er});
        check({tag, " length"}, {27'h0, program_length_out}, {27'h0, el});
        check({tag, " busy"}, {31'h0, busy_out}, {31'h0, eb});
        check({tag, " done"}, {31'h0, done_out}, {31'h0, ed});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_byte_in  = b;
        load_valid_in = 1'b1;
        load_last_in  = last;
        tick();
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], last && (i == 3));
    endtask

    task automatic start_pulse();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    initial begin
        reset_in      = 1'b1;
        load_byte_in  = 8'h00;
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        start_in      = 1'b0;
        cpu_output_in = 4'sd0;
        tick();
        tick();
        check_state("reset", NOP, 1'b1, 5'd0, 1'b0, 1'b0);
        check("reset valid", {31'h0, result_valid_out}, 32'h0);
        check("reset result", {28'h0, result_data_out}, 32'h0);
        reset_in = 1'b0;

        // Start with empty memory, then load 09,03,00,01,0F,00,01,00 and run.
        for (int i = 0; i < 3; i++)
            vecs[i] = mk(8'h00, 0, 0, 1, 4'sd0, NOP, 1, 5'd0, 0, 0, 0, 4'sd0);
        vecs[3]  = mk(8'h09, 1, 0, 0, 4'sd0, NOP, 1, 5'd0, 1, 0, 0, 4'sd0);
        vecs[4]  = mk(8'h03, 1, 0, 0, 4'sd0, NOP, 1, 5'd0, 1, 0, 0, 4'sd0);
        vecs[5]  = mk(8'h00, 1, 0, 0, 4'sd0, NOP, 1, 5'd0, 1, 0, 0, 4'sd0);
        vecs[6]  = mk(8'h01, 1, 0, 0, 4'sd0, NOP, 1, 5'd1, 1, 0, 0, 4'sd0);
        vecs[7]  = mk(8'h0F, 1, 0, 0, 4'sd0, NOP, 1, 5'd1, 1, 0, 0, 4'sd0);
        vecs[8]  = mk(8'h00, 1, 0, 0, 4'sd0, NOP, 1, 5'd1, 1, 0, 0, 4'sd0);
        vecs[9]  = mk(8'h01, 1, 0, 0, 4'sd0, NOP, 1, 5'd1, 1, 0, 0, 4'sd0);
        vecs[10] = mk(8'h00, 1, 1, 0, 4'sd0, NOP, 1, 5'd2, 0, 0, 0, 4'sd0);
        vecs[11] = mk(8'h00, 0, 0, 1, 4'sd0, 32'h0100_0309, 0, 5'd2, 1, 0, 0, 4'sd0);
        vecs[12] = mk(8'h00, 0, 0, 0, 4'sd5, 32'h0001_000F, 0, 5'd2, 1, 0, 0, 4'sd0);
        vecs[13] = mk(8'h00, 0, 0, 0, 4'sd3, NOP, 1, 5'd2, 0, 1, 1, 4'sd3);
        vecs[14] = mk(8'h00, 0, 0, 0, 4'sd7, NOP, 1, 5'd2, 0, 0, 0, 4'sd3);

        for (int i = 0; i < 15; i++) begin
            load_byte_in  = vecs[i].b;
            load_valid_in = vecs[i].v;
            load_last_in  = vecs[i].l;
            start_in      = vecs[i].s;
            cpu_output_in = vecs[i].cpu;
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_ready,
                        vecs[i].e_len, vecs[i].e_busy, vecs[i].e_done);
            check($sformatf("vec%0d valid", i), {31'h0, result_valid_out}, {31'h0, vecs[i].e_valid});
            check($sformatf("vec%0d result", i), {28'h0, result_data_out}, {28'h0, vecs[i].e_res});
        end
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        start_in      = 1'b0;
        cpu_output_in = 4'sd0;

        // Partial final word: upper bytes of word 1 read back as zero.
        send_byte(8'h0B, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h0F, 1);
        check_state("partial loaded", NOP, 1'b1, 5'd2, 1'b0, 1'b0);
        start_pulse();
        check("partial w0", current_instruction_out, 32'h0302_010B);
        tick();
        check("partial w1", current_instruction_out, 32'h0000_000F);
        cpu_output_in = -4'sd2;
        tick();
        check_state("partial end", NOP, 1'b1, 5'd2, 1'b0, 1'b1);
        check("partial valid", {31'h0, result_valid_out}, 32'h1);
        check("partial result", {28'h0, result_data_out}, 32'h0000_000E);
        cpu_output_in = 4'sd0;

        // Tensor-core operate followed by four NOP stall cycles.
        send_word(32'h0000_0005, 0);
        send_word(32'h0000_0010, 1);
        check("stall length", {27'h0, program_length_out}, 32'd2);
        start_pulse();
        check("stall op", current_instruction_out, 32'h0000_0005);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state($sformatf("stall nop%0d", i), NOP, 1'b0, 5'd2, 1'b1, 1'b0);
        end
        tick();
        check("stall w1", current_instruction_out, 32'h0000_0010);
        tick();
        check_state("stall end", NOP, 1'b1, 5'd2, 1'b0, 1'b1);

        // 70 bytes without last: only the first 64 land.
        for (int i = 0; i < 70; i++) begin
            check($sformatf("full ready b%0d", i), {31'h0, load_ready_out}, {31'h0, i < 64});
            send_byte(8'(i), 0);
            if (i == 63)
                check_state("full at 64", NOP, 1'b0, 5'd16, 1'b0, 1'b0);
        end
        check_state("full after 70", NOP, 1'b0, 5'd16, 1'b0, 1'b0);
        start_pulse();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("full w%0d", k), current_instruction_out,
                  {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            tick();
        end
        check_state("full end", NOP, 1'b1, 5'd16, 1'b0, 1'b1);

        // Reset during word 3 of an 8-word program; word 2 is the cpu RESET opcode.
        for (int k = 0; k < 8; k++)
            send_word((k == 2) ? 32'h0000_000D : 32'h0000_0020 + k, k == 7);
        check("rst length", {27'h0, program_length_out}, 32'd8);
        start_pulse();
        check("rst w0", current_instruction_out, 32'h0000_0020);
        tick();
        check("rst w1", current_instruction_out, 32'h0000_0021);
        tick();
        check("rst w2", current_instruction_out, 32'h0000_000D);
        tick();
        check_state("rst w3", 32'h0000_0023, 1'b0, 5'd8, 1'b1, 1'b0);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check_state("rst abort", NOP, 1'b1, 5'd0, 1'b0, 1'b0);
        start_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("rst start%0d", i), NOP, 1'b1, 5'd0, 1'b0, 1'b0);
        end
        start_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program loader and issuer that drives the `cpu` block's 32-bit `current_instruction` input. A byte stream is assembled into 32-bit instruction words and stored in a small program memory. On `start_in`, the stored words are issued to the CPU one per clock, with automatic NOP padding after tensor-core operate instructions. Results of READ instructions are captured from `cpu_output` and presented to the host. The block sits between the host/debug link and `cpu`, and is the producer side of the instruction interface.

## Interface
- `DEPTH`, 16: number of instruction words in program memory (power of two, ≥2).
- `TC_STALL`, 4: NOP cycles inserted after each TENSOR_CORE_OPERATE (opcode 8'h05); 0 disables padding.
- `clock_in` in 1: single clock; all state changes on its rising edge.
- `reset_in` in 1: synchronous, active-high.
- `load_byte_in` in 8: program byte.
- `load_valid_in` in 1: byte present; accepted when `load_valid_in && load_ready_out` at an edge.
- `load_last_in` in 1: qualifies the accepted byte as the final program byte.
- `load_ready_out` out 1: loader can accept a byte.
- `start_in` in 1: level-sampled request to execute the stored program.
- `current_instruction_out` out 32: registered instruction to `cpu.current_instruction`.
- `cpu_output_in` in 4 (signed): `cpu.cpu_output`.
- `result_data_out` out 4 (signed): captured READ result.
- `result_valid_out` out 1: one-cycle pulse with a new `result_data_out`.
- `busy_out` out 1: high in LOAD or RUN.
- `done_out` out 1: one-cycle pulse when a run completes.
- `program_length_out` out $clog2(DEPTH)+1: number of stored words.

## Operation
- NOP word is 32'h0000_0008.
- States are IDLE, LOAD, RUN.
- **IDLE**
  - Output is NOP and `load_ready_out` is 1.
  - An accepted byte starts a new program: write pointer, byte index and length clear, the byte is stored, and the state moves to LOAD.
  - `start_in` with length > 0 moves to RUN with pc = 0. With length = 0, `start_in` is ignored.
- **LOAD**
  - Bytes are packed little-endian: byte index 0 goes to [7:0] (opcode), index 3 goes to [31:24].
  - The 4th byte commits the word to `mem[wr_ptr]`, then `wr_ptr` and the length increment.
  - An accepted byte with `load_last_in`: the word is committed immediately, with unfilled upper bytes forced to 0. The length updates and the state returns to IDLE.
  - When the DEPTH-th word commits, the state returns to IDLE and `load_ready_out` deasserts in that same cycle (combinational on the full count). Further bytes are not accepted until a new program starts.
  - `start_in` is ignored in LOAD.
- **RUN**
  - `load_ready_out` is 0.
  - Each non-stall cycle registers `mem[pc]` onto the output and increments pc.
  - If the issued opcode ([7:0]) is 8'h05, the next TC_STALL cycles issue NOP before continuing (down-counter).
  - After the last word (pc = length−1) and any trailing stall, the next cycle outputs NOP, pulses `done_out` and returns to IDLE.
  - Opcode 8'h0D (RESET) is issued like any other word. It does not reset this block.
- **Result capture** (any state): if the currently registered output opcode is 8'h0F or 8'h10, then at the next edge `result_data_out <= cpu_output_in` and `result_valid_out` pulses for 1 cycle.
- **Reset**
  - `current_instruction_out` = NOP.
  - State = IDLE.
  - pc, `wr_ptr`, byte index, stall counter and `program_length_out` = 0.
  - `result_data_out` = 0.
  - `result_valid_out`, `done_out`, `busy_out` = 0.
  - `load_ready_out` = 1.
  - Memory contents are not cleared.
  - Reset mid-run or mid-load aborts immediately, with no `done_out` pulse.

## Timing
- `start_in` sampled high at edge T: word 0 is visible from T+1. Word k is visible at T+1+k plus the accumulated stall cycles.
- Each issued word is held exactly 1 cycle.
- `done_out` and the NOP output occur in the cycle after the last issue or stall cycle.
- Result latency: READ word visible in cycle C means `result_valid_out` is high in cycle C+1, carrying the `cpu_output_in` value sampled during C.
- Loading: one byte per cycle maximum. `program_length_out` updates the cycle after the committing byte.
- A single-word program with `TC_STALL` = 0 holds RUN for exactly 1 cycle.

## Test plan
- **Reset values:** after reset, the outputs read 32'h00000008, ready = 1, length = 0, and busy/done/valid = 0. `start_in` held for 3 cycles produces no change.
- **Load and run:**
  - Stimulus: bytes 09,03,00,01,0F,00,01,00, with last on the 8th byte.
  - Load response: length = 2.
  - Run response: start gives 32'h01000309, then 32'h0001000F, then NOP with `done_out` = 1.
  - Result: `cpu_output_in` = 4'sd3 during the READ cycle gives `result_data_out` = 3 with valid for 1 cycle.
- **Partial word:** 5 bytes 0B,01,02,03,0F with last on the 5th give length = 2 and word1 = 32'h0000000F.
- **Stall:** program {32'h00000005, 32'h00000010} with `TC_STALL` = 4 gives the operate word for 1 cycle, then 4 NOP cycles, then 32'h00000010, then done.
- **Full:** 70 bytes without last and `DEPTH` = 16: ready drops after the 64th byte, length = 16, and bytes 65–70 are not accepted.
- **Reset mid-run:** an 8-word program with reset asserted during word 3 gives NOP on the next cycle, length = 0, no `done_out`, and a subsequent start is ignored.
